// File: rtl/stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher channels.
package stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } stretch_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stretcher_channel.sv
// One stretch channel: holds the output high for HOLD_CYCLES, then forces a
// GAP_CYCLES low gap, replaying queued events with a saturating pending count.
module stretcher_channel
  import stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 6250000,
  parameter int MAX_PENDING = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_pulse,
  input  logic           i_clear_ovf,
  output logic           o_level,
  output logic           o_busy,
  output logic           o_overflow,
  output stretch_state_t o_state
);

  localparam int CBITS = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int PBITS = $clog2(MAX_PENDING + 1);
  localparam logic [CBITS-1:0] HOLD_LAST = CBITS'(HOLD_CYCLES - 1);
  localparam logic [CBITS-1:0] GAP_LAST  = CBITS'(GAP_CYCLES - 1);
  localparam logic [CBITS-1:0] T_ONE     = CBITS'(1);
  localparam logic [PBITS-1:0] PEND_MAX  = PBITS'(MAX_PENDING);
  localparam logic [PBITS-1:0] P_ONE     = PBITS'(1);

  stretch_state_t   state_q, state_d;
  logic [CBITS-1:0] timer_q, timer_d;
  logic [PBITS-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             level_q, busy_q;
  logic             enq, deq, set_ovf;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deq     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_pulse) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end
      ST_ON: begin
        if (timer_q == HOLD_LAST) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (pend_q != '0) begin
            state_d = ST_ON;
            deq     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // A pulse that coincides with a dequeue cancels out, so it can never overflow.
    enq     = i_pulse && (state_q != ST_IDLE);
    pend_d  = pend_q;
    set_ovf = 1'b0;
    if (enq && !deq) begin
      if (pend_q == PEND_MAX) set_ovf = 1'b1;
      else                    pend_d  = pend_q + P_ONE;
    end else if (!enq && deq) begin
      pend_d = pend_q - P_ONE;
    end

    if (set_ovf)          ovf_d = 1'b1;
    else if (i_clear_ovf) ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE) || (pend_d != '0);
    end
  end

  assign o_level    = level_q;
  assign o_busy     = busy_q;
  assign o_overflow = ovf_q;
  assign o_state    = state_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Array of independent stretch channels turning 1-cycle events into visible levels.
module pulse_stretcher
  import stretcher_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 6250000,
  parameter int MAX_PENDING = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   i_pulse,
  input  logic [CHANNELS-1:0]   i_clear_ovf,
  output logic [CHANNELS-1:0]   o_level,
  output logic [CHANNELS-1:0]   o_busy,
  output logic [CHANNELS-1:0]   o_overflow,
  output logic [2*CHANNELS-1:0] o_dbg_state
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    stretch_state_t st;

    stretcher_channel #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .MAX_PENDING(MAX_PENDING)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_pulse    (i_pulse[g]),
      .i_clear_ovf(i_clear_ovf[g]),
      .o_level    (o_level[g]),
      .o_busy     (o_busy[g]),
      .o_overflow (o_overflow[g]),
      .o_state    (st)
    );

    assign o_dbg_state[2*g +: 2] = st;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD=4, GAP=2, MAX_PENDING=2, 4 channels.
module tb_pulse_stretcher;

  localparam int W = 3;  // {level, busy, overflow} of channel 0

  logic       clk;
  logic       rst;
  logic [3:0] i_pulse;
  logic [3:0] i_clear_ovf;
  logic [3:0] o_level;
  logic [3:0] o_busy;
  logic [3:0] o_overflow;
  logic [7:0] o_dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  pulse_stretcher #(
    .CHANNELS   (4),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .MAX_PENDING(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pulse    (i_pulse),
    .i_clear_ovf(i_clear_ovf),
    .o_level    (o_level),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge that consumed them.
  task automatic cyc(input logic [3:0] p, input logic [3:0] c, input logic r);
    i_pulse     = p;
    i_clear_ovf = c;
    rst         = r;
    @(posedge clk);
    #1;
    i_pulse     = '0;
    i_clear_ovf = '0;
    rst         = 1'b0;
  endtask

  task automatic do_reset();
    cyc(4'b0, 4'b0, 1'b1);
    cyc(4'b0, 4'b0, 1'b1);
  endtask

  function automatic bit in_rng(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  // Pop channel-0 expectations and compare against the DUT.
  task automatic score(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ch0"}, {o_level[0], o_busy[0], o_overflow[0]}, e);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    i_pulse     = '0;
    i_clear_ovf = '0;
    rst         = 1'b1;

    // reset state
    do_reset();
    check("rst_level", o_level, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_state", o_dbg_state, 0);

    // 1: single pulse on ch0
    for (int k = 1; k <= 10; k++) exp_q.push_back({in_rng(k, 1, 4), in_rng(k, 1, 6), 1'b0});
    for (int c = 0; c < 10; c++) begin
      cyc((c == 0) ? 4'b0001 : 4'b0000, 4'b0, 1'b0);
      score("s1");
      check("s1_others", {o_level[3:1], o_busy[3:1], o_overflow[3:1]}, 0);
      if (c + 1 == 1) check("s1_state_on", o_dbg_state[1:0], 1);
      if (c + 1 == 5) check("s1_state_gap", o_dbg_state[1:0], 2);
      if (c + 1 == 7) check("s1_state_idle", o_dbg_state[1:0], 0);
    end

    // 2: pulses at 0,2,3,5; the one at 5 overflows
    do_reset();
    for (int k = 1; k <= 20; k++)
      exp_q.push_back({in_rng(k, 1, 4) | in_rng(k, 7, 10) | in_rng(k, 13, 16),
                       in_rng(k, 1, 18), (k >= 6) ? 1'b1 : 1'b0});
    for (int c = 0; c < 20; c++) begin
      cyc((c == 0 || c == 2 || c == 3 || c == 5) ? 4'b0001 : 4'b0000, 4'b0, 1'b0);
      score("s2");
    end

    // 3: pending=2 and a pulse on the dequeue cycle -> no overflow, three more holds
    do_reset();
    for (int k = 1; k <= 26; k++)
      exp_q.push_back({in_rng(k, 1, 4) | in_rng(k, 7, 10) | in_rng(k, 13, 16) | in_rng(k, 19, 22),
                       in_rng(k, 1, 24), 1'b0});
    for (int c = 0; c < 26; c++) begin
      cyc((c <= 2 || c == 6) ? 4'b0001 : 4'b0000, 4'b0, 1'b0);
      score("s3");
    end

    // 4: reset mid-hold with pending and overflow set aborts everything
    do_reset();
    for (int c = 0; c < 4; c++) cyc(4'b0001, 4'b0, 1'b0);
    check("s4_pre_level", o_level[0], 1);
    check("s4_pre_ovf", o_overflow[0], 1);
    cyc(4'b0, 4'b0, 1'b1);
    check("s4_level", o_level, 0);
    check("s4_busy", o_busy, 0);
    check("s4_ovf", o_overflow, 0);
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0, 4'b0, 1'b0);
      check("s4_no_replay", {o_level, o_busy}, 0);
    end

    // 5: overflow set beats a same-cycle clear; clear alone then wins
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0001, 4'b0, 1'b0);
    check("s5_pre_ovf", o_overflow[0], 0);
    cyc(4'b0001, 4'b0001, 1'b0);
    check("s5_set_dominates", o_overflow[0], 1);
    cyc(4'b0, 4'b0001, 1'b0);
    check("s5_clear", o_overflow[0], 0);
    check("s5_still_busy", o_busy[0], 1);

    // 6: ch0 and ch2 together, ch1/ch3 untouched
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc((c == 0) ? 4'b0101 : 4'b0000, 4'b0, 1'b0);
      check("s6_ch0", o_level[0], in_rng(c + 1, 1, 4));
      check("s6_ch2", o_level[2], in_rng(c + 1, 1, 4));
      check("s6_busy2", o_busy[2], in_rng(c + 1, 1, 6));
      check("s6_idle13", {o_level[3], o_level[1], o_busy[3], o_busy[1]}, 0);
    end

    // 7: lone ch3 pulse stays on ch3
    cyc(4'b1000, 4'b0, 1'b0);
    check("s7_ch3", o_level, 4'b1000);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
